ct_merge_rr: RTL and testbench
==============================

Name: ct_merge_rr

Overview:
- Packet-aware merge node for inputs that may compete, unlike the non-competing one-hot merge.
- Arbitrates NI valid/ready/eop streams onto one output. Round-robin choice is made at packet boundaries; a grant stays locked to one input until that input's eop beat transfers.
- An optional output pipeline register provides timing isolation.
- Sits in the interconnect wherever several producers share one consumer link.

Parameters:
NI, 2, number of input channels (>=1)
WIDTH, 8, payload width per channel in bits
OREG, 1, 1 = registered output stage (1-cycle latency); 0 = combinational output

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
i_data  input  NI*WIDTH  payloads; channel i at bits [WIDTH*i +: WIDTH]
i_valid  input  NI  per-channel beat valid
o_ready  output  NI  per-channel accept; a beat transfers when i_valid[i] & o_ready[i]
i_eop  input  NI  per-channel end-of-packet flag, qualified by i_valid[i]
o_valid  output  1  output beat valid
o_data  output  WIDTH  output payload
i_ready  input  1  downstream accept; an output beat transfers when o_valid & i_ready
o_eop  output  1  output end-of-packet flag

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset state: IDLE; last-granted pointer = NI-1, so input 0 has first priority; output register empty.
- Reset output values: o_valid=0, o_data=0, o_eop=0; o_ready=0 in the reset cycle.
- Source protocol: sources hold valid, data and eop stable until accepted. The arbiter does not require this, but only the accepted beat is forwarded.
- stage_ready: when OREG=1, stage_ready = !full | i_ready. When OREG=0, stage_ready = i_ready.
- FSM, IDLE: grant = first i with i_valid[i], searching from (last+1) mod NI and wrapping. No valid input means no grant.
- IDLE transfer rules: if the granted beat transfers and its eop=0, go to LOCKED with sel=grant. If eop=1, stay IDLE and set last=grant (single-beat packet).
- IDLE, no transfer: the grant is recomputed every cycle, so a newly higher-priority valid may take over before any beat is accepted.
- FSM, LOCKED(sel): grant fixed to sel; every other channel has o_ready=0 regardless of its valid.
- LOCKED transfer rules: an eop beat transfer from sel returns to IDLE with last=sel. A gap in i_valid[sel] holds LOCKED with no output beat.
- o_ready[i] = grant[i] & stage_ready. At most one o_ready bit is high per cycle.
- OREG=1 output stage: a single-entry register.
  - Load {data,eop} when an input transfers.
  - full is set on load and cleared when o_valid & i_ready with no simultaneous load.
  - o_valid=full. Full throughput: 1 beat/cycle with i_ready held high.
  - Latency is exactly 1 cycle from input transfer to o_valid.
  - o_data/o_eop hold their value while o_valid & !i_ready.
- OREG=0 output stage: o_valid = |(grant & i_valid); o_data/o_eop are muxed from the granted channel; zero latency.
- Fairness: after a packet from channel k ends, every other continuously valid channel is served before k again. Worst-case wait is (NI-1) packets.
- NI=1: grant is always channel 0 when valid; behaves as a pass-through with optional register.
- Simultaneous events: an eop transfer and a new candidate in the same cycle give no beat from the new channel until the next cycle (IDLE re-arbitrates then). Load and unload of the register in the same cycle keep full=1.
- Reset mid-packet: lock and register contents are discarded. Downstream sees no terminating eop; packet recovery is the system's responsibility.

Decomposition:
- Package ct_merge_pkg holds:
  - typedef enum {MS_IDLE, MS_LOCKED} merge_state_t
  - function rr_pick(valid, last) returning a one-hot grant, shared with future arbiters
- Sub-module ct_rr_arb (parameter N): inputs req[N], last[$clog2(N)]; output one-hot gnt[N]. Purely combinational, instantiated once.
- The FSM, lock register and output stage stay in ct_merge_rr.

Test Plan:
- Reset: NI=3, OREG=1, all valids high during reset -> o_valid=0 and o_ready=000 during reset. The first post-reset cycle grants input 0 (o_ready=001).
- Contention: NI=3, all inputs stream 1-beat packets (eop=1), i_ready=1 -> output source order 0,1,2,0,1,2, one beat per cycle, with o_valid rising 1 cycle after the first transfer.
- Packet lock: input 0 sends 4 beats (eop on beat 4) with input 1 valid throughout -> o_ready[1]=0 until input 0's eop transfers. Input 1 is granted the following cycle; no interleaving appears on o_data.
- Backpressure: OREG=1, i_ready toggles 1,0,0,1 with data 0xA5 held -> o_data=0xA5 stable while stalled, no beat lost or duplicated, o_ready low only while full & !i_ready.
- Gap in lock: input 2 valid for beat 1, drops i_valid for 3 cycles, then sends eop -> state remains LOCKED; inputs 0/1 remain blocked until that eop transfers.
- Combinational mode: OREG=0, NI=2 -> o_data equals the granted input's data in the same cycle; o_ready[sel] tracks i_ready.

Source files
------------

// File: rtl/ct_merge_pkg.sv
// ---------------------------------------------------------------------------
// ct_merge_pkg
// Shared definitions for the packet-aware round-robin merge node.
//   merge_state_t : arbitration FSM states (free to arbitrate / locked to one
//                   input until its end-of-packet beat transfers)
//   rr_pick()     : round-robin one-hot pick, reusable by other arbiters
// ---------------------------------------------------------------------------
package ct_merge_pkg;

    typedef enum logic [0:0] {
        MS_IDLE   = 1'b0,
        MS_LOCKED = 1'b1
    } merge_state_t;

    // Widest request vector rr_pick() can handle; callers zero-extend into it.
    localparam int unsigned RR_MAX   = 32;
    localparam int unsigned RR_IDX_W = 5;

    // Returns a one-hot grant for the first set bit of valid[n-1:0], searching
    // from (last+1) mod n and wrapping. No valid bit means an all-zero grant.
    function automatic logic [RR_MAX-1:0] rr_pick(
        input logic [RR_MAX-1:0] valid,
        input int unsigned       last,
        input int unsigned       n
    );
        logic [RR_MAX-1:0]   gnt;
        logic [RR_IDX_W-1:0] idx;
        gnt = '0;
        idx = '0;
        for (int unsigned k = 1; k <= RR_MAX; k++) begin
            if (k <= n && gnt == '0) begin
                idx = RR_IDX_W'((last + k) % n);
                if (valid[idx]) begin
                    gnt[idx] = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/ct_rr_arb.sv
// ---------------------------------------------------------------------------
// ct_rr_arb
// Purely combinational round-robin arbiter.
// Ports:
//   req  [N]          request vector
//   last [clog2(N)]   index of the most recently served requester
//   gnt  [N]          one-hot grant (zero when no request)
// ---------------------------------------------------------------------------
module ct_rr_arb
    import ct_merge_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]                          req,
    input  logic [$clog2((N > 1) ? N : 2)-1:0]    last,
    output logic [N-1:0]                          gnt
);

    // The shared picker works on a fixed wide vector; resize in and out.
    always_comb begin
        gnt = N'(rr_pick(RR_MAX'(req), 32'(last), N));
    end

endmodule

// File: rtl/ct_merge_rr.sv
// ---------------------------------------------------------------------------
// ct_merge_rr
// Packet-aware merge of NI valid/ready/eop streams onto one output. A new
// round-robin choice is made only at packet boundaries; once a multi-beat
// packet starts, the grant stays on that input until its eop beat transfers.
// An optional single-entry output register (OREG=1) isolates timing.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   i_data  [NI*WIDTH] input payloads, channel i at [WIDTH*i +: WIDTH]
//   i_valid [NI]       per-channel beat valid
//   i_eop   [NI]       per-channel end-of-packet, qualified by i_valid
//   o_ready [NI]       per-channel accept (at most one bit high)
//   o_valid, o_data, o_eop   merged output beat
//   i_ready            downstream accept
// ---------------------------------------------------------------------------
module ct_merge_rr
    import ct_merge_pkg::*;
#(
    parameter int NI    = 2,
    parameter int WIDTH = 8,
    parameter int OREG  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NI*WIDTH-1:0]   i_data,
    input  logic [NI-1:0]         i_valid,
    output logic [NI-1:0]         o_ready,
    input  logic [NI-1:0]         i_eop,
    output logic                  o_valid,
    output logic [WIDTH-1:0]      o_data,
    input  logic                  i_ready,
    output logic                  o_eop
);

    localparam int LW = (NI > 1) ? $clog2(NI) : 1;

    merge_state_t     state_q, state_d;
    logic [LW-1:0]    last_q, last_d;
    logic [LW-1:0]    sel_q, sel_d;
    logic [LW-1:0]    gntIdx;
    logic [NI-1:0]    arbGnt;
    logic [NI-1:0]    selOneHot;
    logic [NI-1:0]    grant;
    logic [NI-1:0]    xfer;
    logic             stageReady;
    logic             anyXfer;
    logic             muxEop;
    logic [WIDTH-1:0] muxData;

    ct_rr_arb #(.N(NI)) u_arb (
        .req  (i_valid),
        .last (last_q),
        .gnt  (arbGnt)
    );

    always_comb begin
        selOneHot = '0;
        for (int i = 0; i < NI; i++) begin
            selOneHot[i] = (sel_q == LW'(i));
        end
    end

    // Grant is forced off during reset so no input is accepted in that cycle.
    // While locked the grant ignores the other inputs' valids entirely.
    always_comb begin
        if (reset) begin
            grant = '0;
        end else if (state_q == MS_LOCKED) begin
            grant = selOneHot;
        end else begin
            grant = arbGnt;
        end
    end

    assign o_ready = grant & {NI{stageReady}};
    assign xfer    = o_ready & i_valid;
    assign anyXfer = |xfer;

    // Grant is one-hot, so a priority loop acts as a plain mux.
    always_comb begin
        muxData = '0;
        muxEop  = 1'b0;
        gntIdx  = '0;
        for (int i = 0; i < NI; i++) begin
            if (grant[i]) begin
                muxData = i_data[WIDTH*i +: WIDTH];
                muxEop  = i_eop[i];
                gntIdx  = LW'(i);
            end
        end
    end

    // A single-beat packet leaves the FSM idle but still advances the
    // round-robin pointer; a multi-beat packet locks onto its source.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        if (anyXfer) begin
            if (state_q == MS_IDLE) begin
                if (muxEop) begin
                    last_d = gntIdx;
                end else begin
                    state_d = MS_LOCKED;
                    sel_d   = gntIdx;
                end
            end else if (muxEop) begin
                state_d = MS_IDLE;
                last_d  = sel_q;
            end
        end
    end

    // Pointer resets to NI-1 so input 0 has first priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MS_IDLE;
            last_q  <= LW'(NI - 1);
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
        end
    end

    generate
        if (OREG != 0) begin : g_oreg
            logic             full_q, full_d;
            logic             eop_q, eop_d;
            logic [WIDTH-1:0] data_q, data_d;

            // The register can take a new beat when empty or when its current
            // beat leaves this cycle, giving one beat per cycle.
            assign stageReady = !full_q || i_ready;

            always_comb begin
                full_d = full_q;
                data_d = data_q;
                eop_d  = eop_q;
                if (anyXfer) begin
                    full_d = 1'b1;
                    data_d = muxData;
                    eop_d  = muxEop;
                end else if (full_q && i_ready) begin
                    full_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    full_q <= 1'b0;
                    data_q <= '0;
                    eop_q  <= 1'b0;
                end else begin
                    full_q <= full_d;
                    data_q <= data_d;
                    eop_q  <= eop_d;
                end
            end

            assign o_valid = full_q;
            assign o_data  = data_q;
            assign o_eop   = eop_q;
        end else begin : g_comb
            assign stageReady = i_ready;
            assign o_valid    = |(grant & i_valid);
            assign o_data     = muxData;
            assign o_eop      = muxEop;
        end
    endgenerate

endmodule

// File: tb/tb_ct_merge_rr.sv
// ---------------------------------------------------------------------------
// tb_ct_merge_rr
// Bench for the round-robin merge. dutA: NI=3, registered output. dutB: NI=2,
// combinational output. Sources for dutA are per-channel beat queues; the
// expected output order is pushed to a scoreboard as each scenario is set up.
// ---------------------------------------------------------------------------
module tb_ct_merge_rr;

    logic clk;
    logic reset;

    // dutA signals
    logic [23:0] aData;
    logic [2:0]  aValid;
    logic [2:0]  aEop;
    logic [2:0]  aReady;
    logic        aOutValid;
    logic [7:0]  aOutData;
    logic        aOutEop;
    logic        aDsReady;

    // dutB signals
    logic [15:0] bData;
    logic [1:0]  bValid;
    logic [1:0]  bEop;
    logic [1:0]  bReady;
    logic        bOutValid;
    logic [7:0]  bOutData;
    logic        bOutEop;
    logic        bDsReady;

    // Values seen at the most recent mid-cycle sample of dutA
    logic [2:0]  sampReady;
    logic        sampValid;
    logic [7:0]  sampData;
    logic        sampEop;

    // Channel queue entries are {bubble, eop, data}; a bubble holds valid low
    // for one cycle and is then dropped.
    logic [9:0]  chanQ [3][$];
    logic [8:0]  sbQ [$];

    int assertCount;
    int failCount;

    ct_merge_rr #(.NI(3), .WIDTH(8), .OREG(1)) dutA (
        .clk     (clk),
        .reset   (reset),
        .i_data  (aData),
        .i_valid (aValid),
        .o_ready (aReady),
        .i_eop   (aEop),
        .o_valid (aOutValid),
        .o_data  (aOutData),
        .i_ready (aDsReady),
        .o_eop   (aOutEop)
    );

    ct_merge_rr #(.NI(2), .WIDTH(8), .OREG(0)) dutB (
        .clk     (clk),
        .reset   (reset),
        .i_data  (bData),
        .i_valid (bValid),
        .o_ready (bReady),
        .i_eop   (bEop),
        .o_valid (bOutValid),
        .o_data  (bOutData),
        .i_ready (bDsReady),
        .o_eop   (bOutEop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic pushBeat(input int c, input logic eop, input logic [7:0] data);
        chanQ[c].push_back({1'b0, eop, data});
    endtask

    task automatic pushBubble(input int c);
        chanQ[c].push_back(10'h200);
    endtask

    task automatic expectBeat(input logic eop, input logic [7:0] data);
        sbQ.push_back({eop, data});
    endtask

    // One dutA cycle: drive queue heads, sample mid-cycle, score any output
    // beat, then retire accepted beats and bubbles after the edge.
    task automatic applyStimulus();
        logic [2:0] taken;
        logic [9:0] head;
        logic [8:0] expBeat;
        for (int c = 0; c < 3; c++) begin
            aValid[c]         = 1'b0;
            aEop[c]           = 1'b0;
            aData[8*c +: 8]   = 8'h00;
            if (chanQ[c].size() > 0) begin
                head = chanQ[c][0];
                if (!head[9]) begin
                    aValid[c]       = 1'b1;
                    aEop[c]         = head[8];
                    aData[8*c +: 8] = head[7:0];
                end
            end
        end
        @(negedge clk);
        sampReady = aReady;
        sampValid = aOutValid;
        sampData  = aOutData;
        sampEop   = aOutEop;
        taken     = 3'b000;
        if (!reset) begin
            checkOutput("ready_onehot", 32'($countones(aReady) <= 1), 32'd1);
            if (aOutValid && aDsReady) begin
                checkOutput("sb_has_entry", 32'(sbQ.size() > 0), 32'd1);
                if (sbQ.size() > 0) begin
                    expBeat = sbQ.pop_front();
                    checkOutput("sb_beat", 32'({aOutEop, aOutData}), 32'(expBeat));
                end
            end
            for (int c = 0; c < 3; c++) begin
                if (chanQ[c].size() > 0) begin
                    head = chanQ[c][0];
                    taken[c] = head[9] | (aValid[c] & aReady[c]);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            if (taken[c]) begin
                void'(chanQ[c].pop_front());
            end
        end
    endtask

    task automatic drainAndCheck(input string tag);
        int guard = 0;
        while ((sbQ.size() > 0 || chanQ[0].size() > 0 || chanQ[1].size() > 0 ||
                chanQ[2].size() > 0) && guard < 40) begin
            applyStimulus();
            guard++;
        end
        applyStimulus();
        applyStimulus();
        checkOutput({tag, "_sb_empty"}, 32'(sbQ.size()), 32'd0);
        checkOutput({tag, "_src_empty"},
                    32'(chanQ[0].size() + chanQ[1].size() + chanQ[2].size()), 32'd0);
    endtask

    // One dutB cycle with same-cycle checks of the combinational output.
    task automatic applyStimulusB(input string tag, input logic [1:0] v,
                                  input logic [15:0] d, input logic [1:0] e,
                                  input logic r, input logic [1:0] expReady,
                                  input logic expValid, input logic [7:0] expData,
                                  input logic expEop);
        bValid   = v;
        bData    = d;
        bEop     = e;
        bDsReady = r;
        @(negedge clk);
        checkOutput({tag, "_ready"}, 32'(bReady), 32'(expReady));
        checkOutput({tag, "_valid"}, 32'(bOutValid), 32'(expValid));
        checkOutput({tag, "_data"}, 32'(bOutData), 32'(expData));
        checkOutput({tag, "_eop"}, 32'(bOutEop), 32'(expEop));
        @(posedge clk);
        #1;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        reset       = 1'b1;
        aDsReady    = 1'b1;
        aData       = '0;
        aValid      = '0;
        aEop        = '0;
        bData       = '0;
        bValid      = '0;
        bEop        = '0;
        bDsReady    = 1'b0;

        // Contention: every channel offers two single-beat packets, and all
        // are already valid while reset is held.
        for (int n = 0; n < 2; n++) begin
            for (int c = 0; c < 3; c++) begin
                pushBeat(c, 1'b1, 8'(8'h10 * (c + 1) + n));
            end
        end
        for (int n = 0; n < 2; n++) begin
            for (int c = 0; c < 3; c++) begin
                expectBeat(1'b1, 8'(8'h10 * (c + 1) + n));
            end
        end

        applyStimulus();
        applyStimulus();
        checkOutput("rst_a_valid", 32'(sampValid), 32'd0);
        checkOutput("rst_a_ready", 32'(sampReady), 32'd0);
        checkOutput("rst_a_data", 32'(sampData), 32'd0);
        checkOutput("rst_b_valid", 32'(bOutValid), 32'd0);
        checkOutput("rst_b_ready", 32'(bReady), 32'd0);
        checkOutput("rst_b_data", 32'(bOutData), 32'd0);
        reset = 1'b0;

        for (int t = 1; t <= 7; t++) begin
            applyStimulus();
            if (t == 1) begin
                checkOutput("cont_first_ready", 32'(sampReady), 32'b001);
                checkOutput("cont_latency", 32'(sampValid), 32'd0);
            end
            if (t == 2) checkOutput("cont_ready_t2", 32'(sampReady), 32'b010);
            if (t == 3) checkOutput("cont_ready_t3", 32'(sampReady), 32'b100);
            if (t == 4) checkOutput("cont_ready_t4", 32'(sampReady), 32'b001);
            if (t >= 2) checkOutput("cont_stream_valid", 32'(sampValid), 32'd1);
        end
        drainAndCheck("cont");

        // Packet lock: channel 0 sends a single-beat packet (pointer -> 0),
        // then a 4-beat packet; channel 1 joins during the packet and would
        // win a fresh arbitration, but must wait for the eop.
        pushBeat(0, 1'b1, 8'h40);
        pushBeat(0, 1'b0, 8'h41);
        pushBeat(0, 1'b0, 8'h42);
        pushBeat(0, 1'b0, 8'h43);
        pushBeat(0, 1'b1, 8'h44);
        pushBubble(1);
        pushBubble(1);
        pushBeat(1, 1'b1, 8'h50);
        expectBeat(1'b1, 8'h40);
        expectBeat(1'b0, 8'h41);
        expectBeat(1'b0, 8'h42);
        expectBeat(1'b0, 8'h43);
        expectBeat(1'b1, 8'h44);
        expectBeat(1'b1, 8'h50);
        for (int t = 1; t <= 6; t++) begin
            applyStimulus();
            if (t >= 3 && t <= 5) begin
                checkOutput("lock_ch1_blocked", 32'(sampReady[1]), 32'd0);
                checkOutput("lock_ch0_ready", 32'(sampReady), 32'b001);
            end
            if (t == 6) checkOutput("lock_handover", 32'(sampReady), 32'b010);
        end
        drainAndCheck("lock");

        // Backpressure: downstream ready goes 1,0,0,1 around a held 0xA5.
        pushBeat(0, 1'b1, 8'hA5);
        pushBeat(0, 1'b1, 8'h5A);
        expectBeat(1'b1, 8'hA5);
        expectBeat(1'b1, 8'h5A);
        for (int t = 1; t <= 5; t++) begin
            aDsReady = (t == 2 || t == 3) ? 1'b0 : 1'b1;
            applyStimulus();
            if (t == 1) checkOutput("bp_ready_t1", 32'(sampReady), 32'b001);
            if (t == 2 || t == 3) begin
                checkOutput("bp_hold_data", 32'(sampData), 32'hA5);
                checkOutput("bp_hold_valid", 32'(sampValid), 32'd1);
                checkOutput("bp_stall_ready", 32'(sampReady), 32'b000);
            end
            if (t == 4) begin
                checkOutput("bp_release_ready", 32'(sampReady), 32'b001);
                checkOutput("bp_release_data", 32'(sampData), 32'hA5);
            end
            if (t == 5) checkOutput("bp_next_data", 32'(sampData), 32'h5A);
        end
        aDsReady = 1'b1;
        drainAndCheck("bp");

        // Gap in lock: channel 2 starts a packet, idles three cycles, then
        // ends it; channels 0 and 1 wait the whole time.
        pushBeat(2, 1'b0, 8'h61);
        pushBubble(2);
        pushBubble(2);
        pushBubble(2);
        pushBeat(2, 1'b1, 8'h62);
        pushBubble(0);
        pushBeat(0, 1'b1, 8'h71);
        pushBubble(1);
        pushBeat(1, 1'b1, 8'h81);
        expectBeat(1'b0, 8'h61);
        expectBeat(1'b1, 8'h62);
        expectBeat(1'b1, 8'h71);
        expectBeat(1'b1, 8'h81);
        for (int t = 1; t <= 7; t++) begin
            applyStimulus();
            if (t == 1) checkOutput("gap_first_grant", 32'(sampReady), 32'b100);
            if (t == 2) checkOutput("gap_first_eop", 32'(sampEop), 32'd0);
            if (t >= 2 && t <= 5) checkOutput("gap_others_blocked", 32'(sampReady[1:0]), 32'd0);
            if (t >= 3 && t <= 5) checkOutput("gap_no_beat", 32'(sampValid), 32'd0);
            if (t == 6) checkOutput("gap_next_ch0", 32'(sampReady), 32'b001);
            if (t == 7) checkOutput("gap_next_ch1", 32'(sampReady), 32'b010);
        end
        drainAndCheck("gap");

        // Combinational mode on dutB (pointer starts at 1, so channel 0 first)
        applyStimulusB("comb_s1", 2'b11, 16'h2211, 2'b11, 1'b1, 2'b01, 1'b1, 8'h11, 1'b1);
        applyStimulusB("comb_s2", 2'b11, 16'h2211, 2'b11, 1'b1, 2'b10, 1'b1, 8'h22, 1'b1);
        applyStimulusB("comb_s3", 2'b01, 16'h0033, 2'b00, 1'b0, 2'b00, 1'b1, 8'h33, 1'b0);
        applyStimulusB("comb_s4", 2'b01, 16'h0033, 2'b00, 1'b1, 2'b01, 1'b1, 8'h33, 1'b0);
        applyStimulusB("comb_s5", 2'b11, 16'h2234, 2'b11, 1'b1, 2'b01, 1'b1, 8'h34, 1'b1);
        applyStimulusB("comb_s6", 2'b10, 16'h2200, 2'b10, 1'b1, 2'b10, 1'b1, 8'h22, 1'b1);
        applyStimulusB("comb_idle", 2'b00, 16'h0000, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
